// File: rtl/max7219_spi_tx.sv
// MAX7219 serial driver: sends the 5-word init sequence after reset, then on
// each start request streams 8 row words {addr 1..8, col} fetched from a font
// provider. Each word is 16 bits MSB first followed by a LOAD-high latch gap.
module max7219_spi_tx #(
  parameter int unsigned CLK_DIV   = 4,     // clk cycles per SCLK half-period, 1..255
  parameter logic [3:0]  INTENSITY = 4'h8   // brightness written to register 0x0A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] col,
  output logic       enable,
  output logic       din,
  output logic       sclk,
  output logic       load,
  output logic       busy,
  output logic       done
);

  // INIT is a single setup cycle that loads init word 0; the init words
  // themselves shift through SHIFT/LATCH with init_q set, back to back.
  typedef enum logic [2:0] {INIT, IDLE, FETCH, SHIFT, LATCH} state_t;

  localparam logic [8:0] PH_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] LAT_LAST = 9'(2 * CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] word_q,  word_d;   // shift register, bit 15 is on din
  logic [3:0]  bit_q,   bit_d;    // bits completed in the current word
  logic [8:0]  div_q,   div_d;    // cycles within a phase (or within LATCH)
  logic        ph_q,    ph_d;     // 0 = sclk low half, 1 = sclk high half
  logic [2:0]  idx_q,   idx_d;    // init word index or row index
  logic        init_q,  init_d;   // words in flight belong to the init sequence
  logic        done_q,  done_d;

  function automatic logic [15:0] init_word(input logic [2:0] i);
    case (i)
      3'd0:    init_word = 16'h0900;                 // decode mode: none
      3'd1:    init_word = {8'h0A, 4'h0, INTENSITY}; // intensity
      3'd2:    init_word = 16'h0B07;                 // scan limit: all 8 digits
      3'd3:    init_word = 16'h0C01;                 // leave shutdown
      default: init_word = 16'h0F00;                 // display test off
    endcase
  endfunction

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      word_q  <= 16'h0000;
      bit_q   <= 4'd0;
      div_q   <= 9'd0;
      ph_q    <= 1'b0;
      idx_q   <= 3'd0;
      init_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      done_q  <= done_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    div_d   = div_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    init_d  = init_q;
    done_d  = 1'b0;
    case (state_q)
      INIT: begin
        word_d  = init_word(3'd0);
        idx_d   = 3'd0;
        init_d  = 1'b1;
        bit_d   = 4'd0;
        div_d   = 9'd0;
        ph_d    = 1'b0;
        state_d = SHIFT;
      end
      IDLE: begin
        if (start) begin
          idx_d   = 3'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // provider drives col this cycle; row address is 1-based
        word_d  = {4'h0, {1'b0, idx_q} + 4'd1, col};
        bit_d   = 4'd0;
        div_d   = 9'd0;
        ph_d    = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == PH_LAST) begin
          div_d = 9'd0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d   = 1'b0;
            word_d = {word_q[14:0], 1'b0};
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) state_d = LATCH;
          end
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      LATCH: begin
        if (div_q == LAT_LAST) begin
          div_d = 9'd0;
          bit_d = 4'd0;
          ph_d  = 1'b0;
          if (init_q) begin
            if (idx_q == 3'd4) begin
              init_d  = 1'b0;
              state_d = IDLE;
            end else begin
              // next init word follows with no gap
              idx_d   = idx_q + 3'd1;
              word_d  = init_word(idx_q + 3'd1);
              state_d = SHIFT;
            end
          end else if (idx_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = FETCH;
          end
        end else begin
          div_d = div_q + 9'd1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // outputs decode directly from registered state: load high and din low
  // everywhere except while a word is shifting
  assign sclk   = (state_q == SHIFT) && ph_q;
  assign load   = (state_q != SHIFT);
  assign din    = (state_q == SHIFT) && word_q[15];
  assign enable = (state_q == FETCH);
  assign busy   = (state_q != IDLE);
  assign done   = done_q;

endmodule
